// File: rtl/io_pkg.sv
// io_pkg: shared constants for the memory-mapped I/O controller.
//   - Byte offsets of the registers inside the 32-byte window.
//   - Window size and holdoff reload value.
//   - Helper that turns a byte offset into a word index.
package io_pkg;

  localparam int unsigned IO_WIN_SIZE = 32;

  localparam logic [4:0] IO_DATA0 = 5'h00;
  localparam logic [4:0] IO_DATA1 = 5'h04;
  localparam logic [4:0] IO_DATA2 = 5'h08;
  localparam logic [4:0] IO_DATA3 = 5'h0C;
  localparam logic [4:0] IO_DIR   = 5'h10;
  localparam logic [4:0] IO_STAT  = 5'h14;
  localparam logic [4:0] IO_IEN   = 5'h18;

  // Cycles of change-detect suppression after a port turns to input.
  localparam logic [1:0] IO_HOLDOFF = 2'd3;

  function automatic logic [2:0] io_word(input logic [4:0] off);
    return off[4:2];
  endfunction

endpackage

// File: rtl/io_sync.sv
// io_sync: two-flop synchroniser for one 8-bit port read-back byte, plus a
// register holding the previous synchronised value for change detection.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   d_i    [7:0]  : asynchronous port byte
//   sync_o [7:0]  : second synchroniser stage
//   prev_o [7:0]  : sync_o delayed by one cycle
module io_sync (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] d_i,
  output logic [7:0] sync_o,
  output logic [7:0] prev_o
);

  logic [7:0] sync1_q, sync2_q, prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= d_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign sync_o = sync2_q;
  assign prev_o = prev_q;

endmodule

// File: rtl/io_bus_ctrl.sv
// io_bus_ctrl: memory-mapped controller between the core data bus and up to
// four RegIO byte ports. Decodes a 32-byte window, drives port strobes,
// synchronises read-back bytes and raises a sticky, maskable change interrupt.
// Ports:
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   addr_i, wdata_i        : core data address / store data
//   we_i, re_i             : store / load strobes
//   rdata_o                : combinational load data
//   hit_o                  : address lies in the window
//   sel_o, wr_o, rd_o      : RegIO select (one-hot), write strobe, read enable
//   dir_o                  : per-port direction, 1 = input (high-Z)
//   data_o                 : store byte to the ports
//   data_i                 : port k read-back on bits [8k+7:8k]
//   irq_o                  : registered interrupt request
module io_bus_ctrl
  import io_pkg::*;
#(
  parameter int unsigned NPORTS    = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_1000
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [31:0]           addr_i,
  input  logic [31:0]           wdata_i,
  input  logic                  we_i,
  input  logic                  re_i,
  output logic [31:0]           rdata_o,
  output logic                  hit_o,
  output logic [NPORTS-1:0]     sel_o,
  output logic                  wr_o,
  output logic                  rd_o,
  output logic [NPORTS-1:0]     dir_o,
  output logic [7:0]            data_o,
  input  logic [8*NPORTS-1:0]   data_i,
  output logic                  irq_o
);

  logic              hit;
  logic [4:0]        off;
  logic              dir_we, stat_we, ien_we;
  logic              armed;

  logic [NPORTS-1:0] dir_q, dir_d;
  logic [NPORTS-1:0] stat_q, stat_d;
  logic [NPORTS-1:0] ien_q, ien_d;
  logic [NPORTS-1:0] chg;
  logic [1:0]        holdoff_q [NPORTS];
  logic [1:0]        holdoff_d [NPORTS];
  logic [1:0]        armed_cnt_q, armed_cnt_d;
  logic              irq_q, rd_q;

  logic [7:0]        sync2 [NPORTS];
  logic [7:0]        prev  [NPORTS];

  logic              unused_bits;
  assign unused_bits = ^{wdata_i[31:8], addr_i[1:0]};

  for (genvar k = 0; k < NPORTS; k++) begin : g_sync
    io_sync u_sync (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .d_i    (data_i[8*k +: 8]),
      .sync_o (sync2[k]),
      .prev_o (prev[k])
    );
  end

  assign hit     = (addr_i[31:5] == BASE_ADDR[31:5]);
  assign off     = {addr_i[4:2], 2'b00};
  assign dir_we  = we_i & hit & (off == IO_DIR);
  assign stat_we = we_i & hit & (off == IO_STAT);
  assign ien_we  = we_i & hit & (off == IO_IEN);
  assign armed   = (armed_cnt_q == 2'd3);

  // Bus decode: strobes and load data are purely combinational.
  always_comb begin
    sel_o   = '0;
    rdata_o = '0;
    wr_o    = we_i & hit;
    data_o  = wdata_i[7:0];
    if (we_i && hit) begin
      for (int k = 0; k < NPORTS; k++) begin
        if (io_word(off) == 3'(k)) sel_o[k] = 1'b1;
      end
    end
    if (re_i && hit) begin
      case (off)
        IO_DATA0, IO_DATA1, IO_DATA2, IO_DATA3: begin
          for (int k = 0; k < NPORTS; k++) begin
            if (io_word(off) == 3'(k)) rdata_o = {24'b0, sync2[k]};
          end
        end
        IO_DIR:  rdata_o = 32'(dir_q);
        IO_STAT: rdata_o = 32'(stat_q);
        IO_IEN:  rdata_o = 32'(ien_q);
        default: rdata_o = '0;
      endcase
    end
  end

  // Register next-state.
  always_comb begin
    dir_d       = dir_q;
    ien_d       = ien_q;
    stat_d      = stat_q;
    chg         = '0;
    armed_cnt_d = armed ? armed_cnt_q : armed_cnt_q + 2'd1;
    if (dir_we) dir_d = wdata_i[NPORTS-1:0];
    if (ien_we) ien_d = wdata_i[NPORTS-1:0];
    for (int k = 0; k < NPORTS; k++) begin
      holdoff_d[k] = holdoff_q[k];
      // Reload only on a drive -> input transition of this port.
      if (dir_we && !dir_q[k] && wdata_i[k]) begin
        holdoff_d[k] = IO_HOLDOFF;
      end else if (holdoff_q[k] != 2'd0) begin
        holdoff_d[k] = holdoff_q[k] - 2'd1;
      end
      chg[k] = (sync2[k] != prev[k]) && dir_q[k] && armed && (holdoff_q[k] == 2'd0);
    end
    if (stat_we) stat_d = stat_d & ~wdata_i[NPORTS-1:0];
    // Applied after the clear so a coincident set wins.
    stat_d = stat_d | chg;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dir_q       <= '1;
      stat_q      <= '0;
      ien_q       <= '0;
      armed_cnt_q <= '0;
      irq_q       <= 1'b0;
      rd_q        <= 1'b0;
      for (int k = 0; k < NPORTS; k++) holdoff_q[k] <= '0;
    end else begin
      dir_q       <= dir_d;
      stat_q      <= stat_d;
      ien_q       <= ien_d;
      armed_cnt_q <= armed_cnt_d;
      irq_q       <= |(stat_q & ien_q);
      rd_q        <= 1'b1;
      for (int k = 0; k < NPORTS; k++) holdoff_q[k] <= holdoff_d[k];
    end
  end

  assign hit_o = hit;
  assign dir_o = dir_q;
  assign irq_o = irq_q;
  assign rd_o  = rd_q;

endmodule

// File: tb/tb_io_bus_ctrl.sv
module tb_io_bus_ctrl;

  localparam int unsigned NP = 4;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic [31:0]   addr_i, wdata_i;
  logic          we_i, re_i;
  logic [31:0]   rdata_o;
  logic          hit_o, wr_o, rd_o, irq_o;
  logic [NP-1:0] sel_o, dir_o;
  logic [7:0]    data_o;
  logic [8*NP-1:0] data_i;

  always #5 clk_i = ~clk_i;

  io_bus_ctrl #(.NPORTS(NP), .BASE_ADDR(32'h0000_1000)) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .addr_i  (addr_i),
    .wdata_i (wdata_i),
    .we_i    (we_i),
    .re_i    (re_i),
    .rdata_o (rdata_o),
    .hit_o   (hit_o),
    .sel_o   (sel_o),
    .wr_o    (wr_o),
    .rd_o    (rd_o),
    .dir_o   (dir_o),
    .data_o  (data_o),
    .data_i  (data_i),
    .irq_o   (irq_o)
  );

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic expect_v(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $error("FAIL scoreboard_empty: observed %h required nothing pending", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        fails++;
        $error("FAIL %s: observed %h required %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
    addr_i = a;
    re_i   = 1'b1;
    #1;
    d      = rdata_o;
    re_i   = 1'b0;
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    addr_i  = a;
    wdata_i = d;
    we_i    = 1'b1;
    tick();
    we_i    = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] r;
    rst_ni  = 1'b0;
    addr_i  = '0;
    wdata_i = '0;
    we_i    = 1'b0;
    re_i    = 1'b0;
    data_i  = '0;

    // Reset state.
    #12;
    expect_v("rd_in_reset", 32'h0);  check(32'(rd_o));
    expect_v("irq_in_reset", 32'h0); check(32'(irq_o));
    expect_v("dir_o_reset", 32'hF);  check(32'(dir_o));
    #5 rst_ni = 1'b1;
    #1;
    expect_v("rd_before_edge", 32'h0); check(32'(rd_o));
    tick();
    expect_v("rd_after_edge", 32'h1); check(32'(rd_o));

    expect_v("dir_reg_reset", 32'h0000_000F);  bus_rd(32'h1010, r); check(r);
    expect_v("stat_reg_reset", 32'h0);         bus_rd(32'h1014, r); check(r);
    expect_v("ien_reg_reset", 32'h0);          bus_rd(32'h1018, r); check(r);
    expect_v("reserved_read", 32'h0);          bus_rd(32'h101C, r); check(r);
    addr_i = 32'h1010;
    #1;
    expect_v("rdata_no_re", 32'h0); check(rdata_o);

    // Store decode in-window and out-of-window.
    addr_i  = 32'h1004;
    wdata_i = 32'h0000_00A5;
    we_i    = 1'b1;
    #1;
    expect_v("sel_data1", 32'h2);  check(32'(sel_o));
    expect_v("wr_data1", 32'h1);   check(32'(wr_o));
    expect_v("data_o_a5", 32'hA5); check(32'(data_o));
    expect_v("hit_in", 32'h1);     check(32'(hit_o));
    addr_i = 32'h2004;
    #1;
    expect_v("sel_outside", 32'h0); check(32'(sel_o));
    expect_v("wr_outside", 32'h0);  check(32'(wr_o));
    expect_v("hit_outside", 32'h0); check(32'(hit_o));
    tick();
    we_i = 1'b0;
    addr_i = 32'h1008;
    #1;
    expect_v("sel_no_we", 32'h0); check(32'(sel_o));
    repeat (3) tick();

    // Port 0 read-back latency and interrupt.
    bus_wr(32'h1018, 32'h1);
    data_i[7:0] = 8'h3C;
    expect_v("data0_at_n2", 32'h3C);
    expect_v("stat_not_yet_n2", 32'h0);
    expect_v("stat_at_n3", 32'h1);
    expect_v("irq_low_n3", 32'h0);
    expect_v("irq_high_n4", 32'h1);
    tick(); tick();
    bus_rd(32'h1000, r); check(r);
    bus_rd(32'h1014, r); check(r);
    tick();
    bus_rd(32'h1014, r); check(r);
    check(32'(irq_o));
    tick();
    check(32'(irq_o));
    bus_wr(32'h1014, 32'h1);
    expect_v("irq_hold_after_w1c", 32'h1); check(32'(irq_o));
    expect_v("stat_cleared", 32'h0);       bus_rd(32'h1014, r); check(r);
    tick();
    expect_v("irq_low_after_w1c", 32'h0);  check(32'(irq_o));

    // Port 1: output direction masks changes; holdoff after turning to input.
    bus_wr(32'h1010, 32'h0D);
    expect_v("dir_o_0d", 32'hD); check(32'(dir_o));
    data_i[15:8] = 8'h55;
    repeat (5) tick();
    expect_v("stat_port1_output", 32'h0); bus_rd(32'h1014, r); check(r);
    bus_wr(32'h1010, 32'h0F);
    data_i[15:8] = 8'hAA;
    repeat (5) tick();
    expect_v("stat_port1_holdoff", 32'h0); bus_rd(32'h1014, r); check(r);
    data_i[15:8] = 8'h5A;
    repeat (3) tick();
    expect_v("stat_port1_set", 32'h2); bus_rd(32'h1014, r); check(r);
    bus_wr(32'h1014, 32'hF);

    // Port 2: set wins over coincident W1C.
    data_i[23:16] = 8'h11;
    repeat (3) tick();
    expect_v("stat_port2_first", 32'h4); bus_rd(32'h1014, r); check(r);
    data_i[23:16] = 8'h22;
    tick(); tick();
    bus_wr(32'h1014, 32'h4);
    expect_v("stat_port2_set_wins", 32'h4); bus_rd(32'h1014, r); check(r);
    bus_wr(32'h1014, 32'h4);
    expect_v("stat_port2_clear", 32'h0);    bus_rd(32'h1014, r); check(r);

    // All ports flagged, then asynchronous reset mid-cycle.
    bus_wr(32'h1018, 32'hF);
    data_i = ~data_i;
    repeat (3) tick();
    expect_v("stat_all", 32'hF); bus_rd(32'h1014, r); check(r);
    tick();
    expect_v("irq_all", 32'h1);  check(32'(irq_o));
    #2 rst_ni = 1'b0;
    #1;
    expect_v("irq_async_rst", 32'h0);   check(32'(irq_o));
    expect_v("rd_async_rst", 32'h0);    check(32'(rd_o));
    expect_v("dir_o_async_rst", 32'hF); check(32'(dir_o));
    expect_v("stat_async_rst", 32'h0);  bus_rd(32'h1014, r); check(r);
    expect_v("dir_async_rst", 32'hF);   bus_rd(32'h1010, r); check(r);
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (5) tick();
    expect_v("stat_armed_suppress", 32'h0); bus_rd(32'h1014, r); check(r);
    expect_v("ien_after_rst", 32'h0);       bus_rd(32'h1018, r); check(r);

    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_leftover: observed %0d pending required 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
